// File: rtl/hazard_stall_ctrl_pkg.sv
// Shared constants for the pipeline interlock: opcodes, instruction field
// positions and the interlock FSM state encoding.
package hazard_stall_ctrl_pkg;

  localparam logic [4:0] OP_ALU  = 5'b00000;
  localparam logic [4:0] OP_BNE  = 5'b00010;
  localparam logic [4:0] OP_JR   = 5'b00100;
  localparam logic [4:0] OP_ADDI = 5'b00101;
  localparam logic [4:0] OP_BLT  = 5'b00110;
  localparam logic [4:0] OP_SW   = 5'b00111;
  localparam logic [4:0] OP_LW   = 5'b01000;
  localparam logic [4:0] OP_BEX  = 5'b10110;

  localparam int OPC_MSB = 31;
  localparam int OPC_LSB = 27;
  localparam int RD_MSB  = 26;
  localparam int RD_LSB  = 22;
  localparam int RS_MSB  = 21;
  localparam int RS_LSB  = 17;
  localparam int RT_MSB  = 16;
  localparam int RT_LSB  = 12;

  // bex implicitly tests the status register
  localparam logic [4:0] REG_STATUS = 5'd30;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    MD   = 2'd2
  } state_t;

endpackage

// File: rtl/hazard_stall_ctrl_insn_src_decode.sv
// Decodes which registers an instruction reads; slot a carries rd (or r30
// for bex), slot b carries rs, slot c carries rt.
module insn_src_decode
  import hazard_stall_ctrl_pkg::*;
(
  input  logic [31:0] insn,
  output logic [4:0]  src_a,
  output logic [4:0]  src_b,
  output logic [4:0]  src_c,
  output logic        src_a_vld,
  output logic        src_b_vld,
  output logic        src_c_vld
);

  logic [4:0] opc;
  logic       unused_low;

  assign opc        = insn[OPC_MSB:OPC_LSB];
  assign unused_low = ^insn[RT_LSB-1:0];

  always_comb begin
    src_a     = insn[RD_MSB:RD_LSB];
    src_b     = insn[RS_MSB:RS_LSB];
    src_c     = insn[RT_MSB:RT_LSB];
    src_a_vld = 1'b0;
    src_b_vld = 1'b0;
    src_c_vld = 1'b0;
    case (opc)
      OP_ALU: begin
        src_b_vld = 1'b1;
        src_c_vld = 1'b1;
      end
      OP_ADDI, OP_LW: src_b_vld = 1'b1;
      OP_SW, OP_BNE, OP_BLT: begin
        src_a_vld = 1'b1;
        src_b_vld = 1'b1;
      end
      OP_JR: src_a_vld = 1'b1;
      OP_BEX: begin
        src_a     = REG_STATUS;
        src_a_vld = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/hazard_stall_ctrl.sv
// Pipeline interlock: load-use stalls of LOAD_STALL cycles, mult/div busy
// stalls, branch-flush override and a saturating stall-cycle counter.
module hazard_stall_ctrl
  import hazard_stall_ctrl_pkg::*;
#(
  parameter int         LOAD_STALL = 1,
  parameter int         CNT_W      = 16,
  parameter logic [4:0] OP_LW      = 5'b01000
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic [31:0]      fd_insn,
  input  logic [31:0]      dx_insn,
  input  logic             md_start,
  input  logic             md_ready,
  input  logic             flush,
  input  logic             cnt_clr,
  output logic             stall_fd,
  output logic             stall_dx,
  output logic             bubble_dx,
  output logic             bubble_xm,
  output logic             md_busy,
  output logic [CNT_W-1:0] stall_count
);

  localparam logic [3:0]       LOAD_RELOAD = 4'(LOAD_STALL - 2);
  localparam logic [CNT_W-1:0] CNT_MAX     = '1;

  state_t     state;
  logic [3:0] dcnt;
  logic [4:0] src_a, src_b, src_c;
  logic       src_a_vld, src_b_vld, src_c_vld;
  logic [4:0] dx_opc, dx_rd;
  logic       load_use;
  logic       unused_dx;

  insn_src_decode u_fd_src (
    .insn      (fd_insn),
    .src_a     (src_a),
    .src_b     (src_b),
    .src_c     (src_c),
    .src_a_vld (src_a_vld),
    .src_b_vld (src_b_vld),
    .src_c_vld (src_c_vld)
  );

  assign dx_opc    = dx_insn[OPC_MSB:OPC_LSB];
  assign dx_rd     = dx_insn[RD_MSB:RD_LSB];
  assign unused_dx = ^dx_insn[RS_MSB:0];

  assign load_use = (dx_opc == OP_LW) && (dx_rd != 5'd0) &&
                    ((src_a_vld && (src_a == dx_rd)) ||
                     (src_b_vld && (src_b == dx_rd)) ||
                     (src_c_vld && (src_c == dx_rd)));

  // Outputs are Mealy so flush and md_ready take effect in the same cycle;
  // gating with reset_n drops them the moment reset asserts.
  always_comb begin
    stall_fd  = 1'b0;
    stall_dx  = 1'b0;
    bubble_dx = 1'b0;
    bubble_xm = 1'b0;
    md_busy   = 1'b0;
    if (reset_n) begin
      case (state)
        IDLE: if (!flush && !md_start && load_use) begin
          stall_fd  = 1'b1;
          bubble_dx = 1'b1;
        end
        LOAD: if (!flush) begin
          stall_fd  = 1'b1;
          bubble_dx = 1'b1;
        end
        MD: if (!md_ready) begin
          md_busy   = 1'b1;
          stall_fd  = 1'b1;
          stall_dx  = 1'b1;
          bubble_xm = 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      dcnt        <= 4'd0;
      stall_count <= '0;
    end else begin
      if (cnt_clr)
        stall_count <= '0;
      else if (stall_fd && (stall_count != CNT_MAX))
        stall_count <= stall_count + 1'b1;

      case (state)
        IDLE: if (!flush) begin
          if (md_start) begin
            if (!md_ready) state <= MD;
          end else if (load_use && (LOAD_STALL > 1)) begin
            state <= LOAD;
            dcnt  <= LOAD_RELOAD;
          end
        end
        LOAD: begin
          if (flush) begin
            state <= IDLE;
            dcnt  <= 4'd0;
          end else if (dcnt == 4'd0) begin
            state <= IDLE;
          end else begin
            dcnt <= dcnt - 1'b1;
          end
        end
        MD: if (md_ready) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Bench for hazard_stall_ctrl: two instances (LOAD_STALL=1/CNT_W=16 and
// LOAD_STALL=3/CNT_W=4) against a remaining-cycles reference model.
module tb_hazard_stall_ctrl;

  logic        clock;
  logic        reset_n;
  logic [31:0] fd_insn, dx_insn;
  logic        md_start, md_ready, flush, cnt_clr;
  logic        sfd[2], sdx[2], bdx[2], bxm[2], busy[2];
  logic [15:0] cnt1;
  logic [3:0]  cnt3;

  int n_vec = 0;
  int n_err = 0;

  int m_ls[2]  = '{1, 3};
  int m_max[2] = '{65535, 15};
  int m_left[2];
  bit m_md[2];
  int m_cnt[2];
  bit e_sfd[2], e_sdx[2], e_bdx[2], e_bxm[2], e_busy[2];

  hazard_stall_ctrl #(.LOAD_STALL(1), .CNT_W(16), .OP_LW(5'b01000)) u_dut1 (
    .clock(clock), .reset_n(reset_n), .fd_insn(fd_insn), .dx_insn(dx_insn),
    .md_start(md_start), .md_ready(md_ready), .flush(flush), .cnt_clr(cnt_clr),
    .stall_fd(sfd[0]), .stall_dx(sdx[0]), .bubble_dx(bdx[0]), .bubble_xm(bxm[0]),
    .md_busy(busy[0]), .stall_count(cnt1)
  );

  hazard_stall_ctrl #(.LOAD_STALL(3), .CNT_W(4), .OP_LW(5'b01000)) u_dut3 (
    .clock(clock), .reset_n(reset_n), .fd_insn(fd_insn), .dx_insn(dx_insn),
    .md_start(md_start), .md_ready(md_ready), .flush(flush), .cnt_clr(cnt_clr),
    .stall_fd(sfd[1]), .stall_dx(sdx[1]), .bubble_dx(bdx[1]), .bubble_xm(bxm[1]),
    .md_busy(busy[1]), .stall_count(cnt3)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_vec++;
    if (obs !== exp_v) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  function automatic logic [31:0] mk(input logic [4:0] op, input logic [4:0] rd,
                                     input logic [4:0] rs, input logic [4:0] rt);
    logic [11:0] noise;
    noise = 12'($urandom);
    return {op, rd, rs, rt, noise};
  endfunction

  // Which registers does fd read, and does the dx load write one of them?
  function automatic bit hazard(input logic [31:0] fd, input logic [31:0] dx);
    logic [4:0] srcs[$];
    logic [4:0] rd, rs, rt;
    rd = fd[26:22]; rs = fd[21:17]; rt = fd[16:12];
    if (dx[31:27] != 5'b01000 || dx[26:22] == 5'd0) return 1'b0;
    case (fd[31:27])
      5'b00000: begin srcs.push_back(rs); srcs.push_back(rt); end
      5'b00101, 5'b01000: srcs.push_back(rs);
      5'b00111, 5'b00010, 5'b00110: begin srcs.push_back(rd); srcs.push_back(rs); end
      5'b00100: srcs.push_back(rd);
      5'b10110: srcs.push_back(5'd30);
      default: ;
    endcase
    foreach (srcs[i]) if (srcs[i] == dx[26:22]) return 1'b1;
    return 1'b0;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_left[k] = 0; m_md[k] = 1'b0; m_cnt[k] = 0;
    end
  endtask

  task automatic model_out();
    bit hz;
    hz = hazard(fd_insn, dx_insn);
    for (int k = 0; k < 2; k++) begin
      e_sfd[k] = 0; e_sdx[k] = 0; e_bdx[k] = 0; e_bxm[k] = 0; e_busy[k] = 0;
      if (!reset_n) continue;
      if (m_md[k]) begin
        if (!md_ready) begin
          e_sfd[k] = 1; e_sdx[k] = 1; e_bxm[k] = 1; e_busy[k] = 1;
        end
      end else if (m_left[k] > 0) begin
        if (!flush) begin e_sfd[k] = 1; e_bdx[k] = 1; end
      end else if (!flush && !md_start && hz) begin
        e_sfd[k] = 1; e_bdx[k] = 1;
      end
    end
  endtask

  task automatic model_step();
    bit hz;
    hz = hazard(fd_insn, dx_insn);
    for (int k = 0; k < 2; k++) begin
      if (cnt_clr) m_cnt[k] = 0;
      else if (e_sfd[k] && m_cnt[k] < m_max[k]) m_cnt[k]++;
      if (m_md[k]) begin
        if (md_ready) m_md[k] = 1'b0;
      end else if (m_left[k] > 0) begin
        m_left[k] = flush ? 0 : m_left[k] - 1;
      end else if (!flush) begin
        if (md_start) begin
          if (!md_ready) m_md[k] = 1'b1;
        end else if (hz) begin
          m_left[k] = m_ls[k] - 1;
        end
      end
    end
  endtask

  task automatic set_in(input logic [31:0] fd, input logic [31:0] dx, input logic ms,
                        input logic mr, input logic fl, input logic clr);
    fd_insn = fd; dx_insn = dx; md_start = ms; md_ready = mr; flush = fl; cnt_clr = clr;
  endtask

  task automatic cycle();
    @(negedge clock);
    model_out();
    for (int k = 0; k < 2; k++) begin
      check_val($sformatf("stall_fd[%0d]", k),  32'(sfd[k]),  32'(e_sfd[k]));
      check_val($sformatf("stall_dx[%0d]", k),  32'(sdx[k]),  32'(e_sdx[k]));
      check_val($sformatf("bubble_dx[%0d]", k), 32'(bdx[k]),  32'(e_bdx[k]));
      check_val($sformatf("bubble_xm[%0d]", k), 32'(bxm[k]),  32'(e_bxm[k]));
      check_val($sformatf("md_busy[%0d]", k),   32'(busy[k]), 32'(e_busy[k]));
    end
    check_val("stall_count[0]", 32'(cnt1), 32'(m_cnt[0]));
    check_val("stall_count[1]", 32'(cnt3), 32'(m_cnt[1]));
    @(posedge clock);
    model_step();
    #1;
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      set_in(32'h0, 32'h0, 0, 0, 0, 0);
      cycle();
    end
  endtask

  // Assert reset away from the clock edge; outputs must drop at once.
  task automatic async_reset(input string tag);
    reset_n = 1'b0;
    #2;
    for (int k = 0; k < 2; k++) begin
      check_val({tag, "_sfd"},  32'(sfd[k]),  32'd0);
      check_val({tag, "_sdx"},  32'(sdx[k]),  32'd0);
      check_val({tag, "_bdx"},  32'(bdx[k]),  32'd0);
      check_val({tag, "_bxm"},  32'(bxm[k]),  32'd0);
      check_val({tag, "_busy"}, 32'(busy[k]), 32'd0);
    end
    check_val({tag, "_cnt1"}, 32'(cnt1), 32'd0);
    check_val({tag, "_cnt3"}, 32'(cnt3), 32'd0);
    model_reset();
    set_in(32'h0, 32'h0, 0, 0, 0, 0);
    @(posedge clock);
    #1;
    reset_n = 1'b1;
  endtask

  function automatic logic [4:0] rreg();
    int r;
    r = $urandom_range(0, 4);
    return (r == 4) ? 5'd30 : 5'(r);
  endfunction

  function automatic logic [4:0] ropc();
    logic [4:0] tbl[9];
    tbl = '{5'b00000, 5'b00101, 5'b01000, 5'b00111, 5'b00010,
            5'b00110, 5'b00100, 5'b10110, 5'b11111};
    return tbl[$urandom_range(0, 8)];
  endfunction

  logic [31:0] lw5, lw0, lw7, add_r5, add_r0, sw_r7;

  initial begin
    model_reset();
    set_in(32'h0, 32'h0, 0, 0, 0, 0);
    reset_n = 1'b0;
    #1;
    async_reset("por");

    // Load-use through rs, single-cycle stall in dut1, three cycles in dut3
    lw5    = mk(5'b01000, 5'd5, 5'd3, 5'd0);
    add_r5 = mk(5'b00000, 5'd1, 5'd5, 5'd2);
    set_in(add_r5, lw5, 0, 0, 0, 0);
    #1;
    check_val("lu1_sfd", 32'(sfd[0]), 32'd1);
    check_val("lu1_bdx", 32'(bdx[0]), 32'd1);
    cycle();
    set_in(add_r5, 32'h0, 0, 0, 0, 0);
    #1;
    check_val("lu1_done", 32'(sfd[0]), 32'd0);
    cycle();
    idle_cycles(2);
    check_val("lu1_cnt1", 32'(cnt1), 32'd1);
    check_val("lu3_cnt3", 32'(cnt3), 32'd3);

    // lw to r0 never interlocks; sw reading rd does
    lw0    = mk(5'b01000, 5'd0, 5'd1, 5'd0);
    add_r0 = mk(5'b00000, 5'd2, 5'd0, 5'd0);
    set_in(add_r0, lw0, 0, 0, 0, 0);
    #1;
    check_val("r0_nostall", 32'(sfd[0]), 32'd0);
    cycle();
    lw7   = mk(5'b01000, 5'd7, 5'd1, 5'd0);
    sw_r7 = mk(5'b00111, 5'd7, 5'd4, 5'd0);
    set_in(sw_r7, lw7, 0, 0, 0, 0);
    #1;
    check_val("sw_rd_stall", 32'(sfd[0]), 32'd1);
    cycle();
    idle_cycles(3);

    // Flush on the second cycle of a three-cycle load stall
    async_reset("rst_a");
    set_in(add_r5, lw5, 0, 0, 0, 0);
    cycle();
    set_in(add_r5, 32'h0, 0, 0, 1, 0);
    #1;
    check_val("flush_drop", 32'(sfd[1]), 32'd0);
    cycle();
    set_in(add_r5, 32'h0, 0, 0, 0, 0);
    #1;
    check_val("flush_idle", 32'(sfd[1]), 32'd0);
    cycle();
    check_val("flush_cnt3", 32'(cnt3), 32'd1);

    // Mult/div: start, four busy cycles, result cycle
    async_reset("rst_b");
    set_in(32'h0, 32'h0, 1, 0, 0, 0);
    cycle();
    for (int i = 0; i < 4; i++) begin
      set_in(32'h0, 32'h0, 0, 0, 0, 0);
      #1;
      check_val("md_busy_on", 32'(busy[0]), 32'd1);
      check_val("md_sdx_on", 32'(sdx[1]), 32'd1);
      cycle();
    end
    set_in(32'h0, 32'h0, 0, 1, 0, 0);
    #1;
    check_val("md_ready_busy", 32'(busy[0]), 32'd0);
    check_val("md_ready_sfd", 32'(sfd[1]), 32'd0);
    cycle();
    idle_cycles(1);
    check_val("md_cnt1", 32'(cnt1), 32'd4);
    check_val("md_cnt3", 32'(cnt3), 32'd4);

    // Zero-latency op, then saturate dut3's 4-bit counter and clear
    set_in(32'h0, 32'h0, 1, 1, 0, 0);
    #1;
    check_val("md_zero_lat", 32'(sfd[0]), 32'd0);
    cycle();
    set_in(32'h0, 32'h0, 1, 0, 0, 0);
    cycle();
    for (int i = 0; i < 20; i++) begin
      set_in(32'h0, 32'h0, 0, 0, 0, 0);
      cycle();
    end
    set_in(32'h0, 32'h0, 0, 1, 0, 0);
    cycle();
    check_val("sat_cnt3", 32'(cnt3), 32'd15);
    set_in(32'h0, 32'h0, 1, 1, 0, 0);
    cycle();
    check_val("sat_hold", 32'(cnt3), 32'd15);
    check_val("cnt1_nosat", 32'(cnt1), 32'd24);
    set_in(32'h0, 32'h0, 0, 0, 0, 1);
    cycle();
    check_val("clr_cnt1", 32'(cnt1), 32'd0);
    check_val("clr_cnt3", 32'(cnt3), 32'd0);

    // Reset mid-LOAD with the hazard still on the inputs, then mid-MD
    set_in(add_r5, lw5, 0, 0, 0, 0);
    cycle();
    set_in(add_r5, lw5, 0, 0, 0, 0);
    #1;
    async_reset("rst_load");
    idle_cycles(2);
    set_in(32'h0, 32'h0, 1, 0, 0, 0);
    cycle();
    set_in(32'h0, 32'h0, 0, 0, 0, 0);
    cycle();
    async_reset("rst_md");
    idle_cycles(2);

    // Randomized traffic
    for (int i = 0; i < 1500; i++) begin
      logic [31:0] fd, dx;
      fd = mk(ropc(), rreg(), rreg(), rreg());
      dx = ($urandom_range(0, 1) == 1) ? mk(5'b01000, rreg(), rreg(), rreg())
                                       : mk(ropc(), rreg(), rreg(), rreg());
      set_in(fd, dx, ($urandom_range(0, 99) < 8), ($urandom_range(0, 99) < 35),
             ($urandom_range(0, 99) < 8), ($urandom_range(0, 99) < 2));
      cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
